// File: rtl/nios2_jtag_debug_ocimem_if.sv
// JTAG command / CPU debug-slave bundle for the on-chip debug memory controller.
interface nios2_jtag_debug_ocimem_if #(
    parameter int ADDR_W = 8
);
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_no_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic [ADDR_W-1:0] cpu_address;
    logic              cpu_read;
    logic              cpu_write;
    logic [31:0]       cpu_writedata;
    logic [3:0]        cpu_byteenable;
    logic              cpu_debugaccess;
    logic [31:0]       cpu_readdata;
    logic              cpu_waitrequest;
    logic [31:0]       MonDReg;
    logic [ADDR_W-1:0] MonAReg;
    logic              jtag_busy;
    logic              jtag_overrun;

    modport master (
        output jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
        output cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable, cpu_debugaccess,
        input  cpu_readdata, cpu_waitrequest, MonDReg, MonAReg, jtag_busy, jtag_overrun
    );

    modport slave (
        input  jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
        input  cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable, cpu_debugaccess,
        output cpu_readdata, cpu_waitrequest, MonDReg, MonAReg, jtag_busy, jtag_overrun
    );
endinterface

// File: rtl/nios2_jtag_debug_ocimem.sv
// Debug RAM shared between JTAG host commands (priority) and the CPU debug slave.
// OCIMEM_BYTE_WRITE_EN: when defined, CPU writes honour cpu_byteenable per lane.
module nios2_jtag_debug_ocimem #(
    parameter int ADDR_W = 8
) (
    input logic                      clk,
    input logic                      reset_n,
    nios2_jtag_debug_ocimem_if.slave bus
);
    typedef enum logic [2:0] {IDLE, JRD, JRD_DATA, JWR, CRD, CRD_DATA, CWR} state_t;

    state_t            state_q, state_d;
    logic [31:0]       mem [2**ADDR_W];
    logic [31:0]       ram_q;
    logic [31:0]       mon_d_q;
    logic [31:0]       cpu_rdata_q;
    logic [ADDR_W-1:0] mon_a_q;
    logic [ADDR_W-1:0] jdo_addr;
    logic              pend_rd_q, pend_wr_q, cpu_ack_q, overrun_q;
    logic              busy, any_cmd, acc_a, acc_n, acc_b, rd_req, wr_req;
    logic [3:0]        cpu_be;

    if (ADDR_W <= 8) begin : g_addr_narrow
        assign jdo_addr = bus.jdo[26 +: ADDR_W];
    end else begin : g_addr_wide
        assign jdo_addr = {{(ADDR_W-8){1'b0}}, bus.jdo[33:26]};
    end

`ifdef OCIMEM_BYTE_WRITE_EN
    assign cpu_be = bus.cpu_byteenable;
`else
    assign cpu_be = 4'hF;
`endif

    assign busy    = pend_rd_q | pend_wr_q | (state_q == JRD) | (state_q == JRD_DATA) | (state_q == JWR);
    assign any_cmd = bus.take_action_ocimem_a | bus.take_no_action_ocimem_a | bus.take_action_ocimem_b;

    // Only one command is accepted per idle window; priority b > a > no_action.
    assign acc_b = bus.take_action_ocimem_b & ~busy;
    assign acc_a = bus.take_action_ocimem_a & ~bus.take_action_ocimem_b & ~busy;
    assign acc_n = bus.take_no_action_ocimem_a & ~bus.take_action_ocimem_a
                   & ~bus.take_action_ocimem_b & ~busy;

    // Accepted pulses bypass the pending register so IDLE can dispatch them at once.
    assign rd_req = pend_rd_q | (acc_a & bus.jdo[17]) | acc_n;
    assign wr_req = pend_wr_q | acc_b;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rd_req)             state_d = JRD;
                else if (wr_req)        state_d = JWR;
                else if (bus.cpu_read)  state_d = CRD;
                else if (bus.cpu_write) state_d = CWR;
            end
            JRD:      state_d = JRD_DATA;
            CRD:      state_d = CRD_DATA;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pend_rd_q   <= 1'b0;
            pend_wr_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            overrun_q   <= 1'b0;
            mon_a_q     <= '0;
            mon_d_q     <= '0;
            cpu_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cpu_ack_q <= (state_d == CWR) | (state_d == CRD_DATA);

            if (any_cmd & busy) overrun_q <= 1'b1;
            else if (acc_a)     overrun_q <= 1'b0;

            if (state_q == JRD_DATA)           pend_rd_q <= 1'b0;
            else if ((acc_a & bus.jdo[17]) | acc_n) pend_rd_q <= 1'b1;

            if (state_q == JWR) pend_wr_q <= 1'b0;
            else if (acc_b)     pend_wr_q <= 1'b1;

            if (acc_a)                mon_a_q <= jdo_addr;
            else if (acc_n)           mon_a_q <= mon_a_q + 1'b1;
            else if (state_q == JWR)  mon_a_q <= mon_a_q + 1'b1;

            if (acc_b)                     mon_d_q <= bus.jdo[34:3];
            else if (state_q == JRD_DATA)  mon_d_q <= ram_q;

            if (state_q == CRD) cpu_rdata_q <= mem[bus.cpu_address];
        end
    end

    // RAM contents are deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (state_q == JWR) begin
            mem[mon_a_q] <= mon_d_q;
        end else if (state_q == CWR && bus.cpu_debugaccess) begin
            for (int i = 0; i < 4; i++)
                if (cpu_be[i]) mem[bus.cpu_address][8*i +: 8] <= bus.cpu_writedata[8*i +: 8];
        end
        if (state_q == JRD) ram_q <= mem[mon_a_q];
    end

    assign bus.cpu_waitrequest = (bus.cpu_read | bus.cpu_write) & ~cpu_ack_q;
    assign bus.cpu_readdata    = cpu_rdata_q;
    assign bus.MonDReg         = mon_d_q;
    assign bus.MonAReg         = mon_a_q;
    assign bus.jtag_busy       = busy;
    assign bus.jtag_overrun    = overrun_q;
endmodule
